ser_frame_tx: RTL and testbench

- Parallel-to-serial frame transmitter; sits directly upstream of the 4-stage serial shift register and drives its single-bit din.
- Accepts a WIDTH-bit word on a valid/ready handshake and emits one frame, one bit per clk: start bit (1), then WIDTH data bits, then an optional parity bit.
- The line idles at 0 between frames, so the downstream shift register flushes zeros when no frame is in flight.

---
 rtl/ser_pkg.sv | 18 +
 rtl/ser_frame_tx_if.sv | 11 +
 rtl/ser_frame_tx.sv | 109 ++++++++++
 tb/tb_ser_frame_tx.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared states, line levels and frame length for the serial frame transmitter
package ser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        DATA   = 2'd2,
        PARITY = 2'd3
    } ser_state_t;

    localparam logic START_BIT  = 1'b1;
    localparam logic IDLE_LEVEL = 1'b0;

    function automatic int frame_len(input int width, input bit parity_en);
        return 1 + width + (parity_en ? 1 : 0);
    endfunction

endpackage

// File: rtl/ser_frame_tx_if.sv
// rtl/ser_frame_tx_if.sv - word handshake into the serial frame transmitter
interface ser_frame_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/ser_frame_tx.sv
// rtl/ser_frame_tx.sv - parallel-to-serial frame transmitter: start bit, WIDTH data bits, optional parity
// Optional even parity bit enabled by defining SER_TX_PARITY_EN.
module ser_frame_tx
    import ser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    ser_frame_tx_if.slave      s,
    output logic               dout,
    output logic               busy,
    output logic               frame_done
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    ser_state_t        state;
    logic [WIDTH-1:0]  shreg;
    logic [WIDTH-1:0]  shifted;
    logic [CW-1:0]     cnt;
    logic              next_bit;
`ifdef SER_TX_PARITY_EN
    logic              par;
`endif

    assign s.in_ready = (state == IDLE);

    // The next outgoing bit always sits at the shift end of shreg.
    always_comb begin
        next_bit = 1'b0;
        shifted  = '0;
        if (LSB_FIRST) begin
            next_bit = shreg[0];
            shifted  = shreg >> 1;
        end else begin
            next_bit = shreg[WIDTH-1];
            shifted  = shreg << 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dout       <= IDLE_LEVEL;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            shreg      <= '0;
            cnt        <= '0;
`ifdef SER_TX_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (s.in_valid) begin
                        shreg <= s.in_data;
                        cnt   <= '0;
`ifdef SER_TX_PARITY_EN
                        par   <= ^s.in_data;
`endif
                        state <= START;
                        dout  <= START_BIT;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    state <= DATA;
                    dout  <= next_bit;
                    shreg <= shifted;
                end
                DATA: begin
                    if (cnt == LAST) begin
`ifdef SER_TX_PARITY_EN
                        state      <= PARITY;
                        dout       <= par;
`else
                        state      <= IDLE;
                        dout       <= IDLE_LEVEL;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
`endif
                    end else begin
                        cnt   <= cnt + 1'b1;
                        dout  <= next_bit;
                        shreg <= shifted;
                    end
                end
`ifdef SER_TX_PARITY_EN
                PARITY: begin
                    state      <= IDLE;
                    dout       <= IDLE_LEVEL;
                    busy       <= 1'b0;
                    frame_done <= 1'b1;
                end
`endif
                default: begin
                    state <= IDLE;
                    dout  <= IDLE_LEVEL;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ser_frame_tx.sv
// tb/tb_ser_frame_tx.sv - directed self-checking bench for ser_frame_tx (MSB-first and LSB-first instances)
module tb_ser_frame_tx;
    import ser_pkg::*;

    localparam int W = 8;
`ifdef SER_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int F = frame_len(W, PAR);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ser_frame_tx_if #(.WIDTH(W)) if_m ();
    ser_frame_tx_if #(.WIDTH(W)) if_l ();

    logic dout_m, busy_m, fd_m;
    logic dout_l, busy_l, fd_l;

    ser_frame_tx #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
        .clk        (clk),
        .rst_n      (rst_n),
        .s          (if_m.slave),
        .dout       (dout_m),
        .busy       (busy_m),
        .frame_done (fd_m)
    );

    ser_frame_tx #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
        .clk        (clk),
        .rst_n      (rst_n),
        .s          (if_l.slave),
        .dout       (dout_l),
        .busy       (busy_l),
        .frame_done (fd_l)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Expected line level at cycle i after the accepting edge (1 = start bit).
    function automatic logic exp_bit(input bit lsb, input logic [7:0] d, input int i);
        if (i == 1) return 1'b1;
        if (i >= 2 && i <= W + 1) return lsb ? d[i-2] : d[W-1-(i-2)];
        if (PAR && i == W + 2) return ^d;
        return 1'b0;
    endfunction

    task automatic drive(input logic [7:0] d, input logic v);
        if_m.in_data  = d;
        if_l.in_data  = d;
        if_m.in_valid = v;
        if_l.in_valid = v;
    endtask

    task automatic test_reset();
        logic [7:0] obs;
        rst_n = 1'b0;
        drive(8'h00, 1'b0);
        repeat (3) @(negedge clk);
        obs = {dout_m, busy_m, fd_m, if_m.in_ready, dout_l, busy_l, fd_l, if_l.in_ready};
        total_cnt++;
        if (obs !== 8'b0001_0001) $display("FAIL reset_held obs=%b exp=00010001", obs);
        else pass_cnt++;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            obs = {dout_m, busy_m, fd_m, if_m.in_ready, dout_l, busy_l, fd_l, if_l.in_ready};
            total_cnt++;
            if (obs !== 8'b0001_0001) $display("FAIL idle_after_reset cyc=%0d obs=%b exp=00010001", i, obs);
            else pass_cnt++;
        end
    endtask

    task automatic test_single_frame(input string name, input logic [7:0] d);
        logic [3:0] obs_m, obs_l, exp_m, exp_l;
        @(negedge clk);
        total_cnt++;
        if (if_m.in_ready !== 1'b1 || if_l.in_ready !== 1'b1)
            $display("FAIL %s_ready_before m=%b l=%b exp=1", name, if_m.in_ready, if_l.in_ready);
        else pass_cnt++;
        drive(d, 1'b1);
        @(posedge clk);
        #1 drive(d, 1'b0);
        for (int i = 1; i <= F + 1; i++) begin
            @(negedge clk);
            obs_m = {dout_m, fd_m, busy_m, if_m.in_ready};
            obs_l = {dout_l, fd_l, busy_l, if_l.in_ready};
            exp_m = {exp_bit(1'b0, d, i), i == F + 1, i <= F, i == F + 1};
            exp_l = {exp_bit(1'b1, d, i), i == F + 1, i <= F, i == F + 1};
            total_cnt++;
            if (obs_m !== exp_m) $display("FAIL %s_msb cyc=%0d {dout,done,busy,ready}=%b exp=%b", name, i, obs_m, exp_m);
            else pass_cnt++;
            total_cnt++;
            if (obs_l !== exp_l) $display("FAIL %s_lsb cyc=%0d {dout,done,busy,ready}=%b exp=%b", name, i, obs_l, exp_l);
            else pass_cnt++;
        end
    endtask

    task automatic test_frames();
        test_single_frame("frame_0f", 8'h0F);
        test_single_frame("frame_c3", 8'hC3);
    endtask

    task automatic test_back_to_back();
        logic [3:0] obs_m, obs_l, exp_m, exp_l;
        logic [7:0] w;
        int         j;
        @(negedge clk);
        drive(8'hA5, 1'b1);
        @(posedge clk);
        for (int i = 1; i <= 2 * F + 2; i++) begin
            @(negedge clk);
            if (i == 1) drive(8'h3C, 1'b1);
            if (i <= F + 1) begin
                j = i;
                w = 8'hA5;
            end else begin
                j = i - F - 1;
                w = 8'h3C;
            end
            obs_m = {dout_m, fd_m, busy_m, if_m.in_ready};
            obs_l = {dout_l, fd_l, busy_l, if_l.in_ready};
            exp_m = {exp_bit(1'b0, w, j), j == F + 1, j <= F, j == F + 1};
            exp_l = {exp_bit(1'b1, w, j), j == F + 1, j <= F, j == F + 1};
            total_cnt++;
            if (obs_m !== exp_m) $display("FAIL b2b_msb cyc=%0d {dout,done,busy,ready}=%b exp=%b", i, obs_m, exp_m);
            else pass_cnt++;
            total_cnt++;
            if (obs_l !== exp_l) $display("FAIL b2b_lsb cyc=%0d {dout,done,busy,ready}=%b exp=%b", i, obs_l, exp_l);
            else pass_cnt++;
            if (i == F + 2) drive(8'h3C, 1'b0);
        end
    endtask

    task automatic test_abort();
        logic [7:0] obs;
        @(negedge clk);
        drive(8'hFF, 1'b1);
        @(posedge clk);
        #1 drive(8'hFF, 1'b0);
        repeat (5) @(negedge clk);
        total_cnt++;
        if ({dout_m, dout_l, busy_m, busy_l} !== 4'b1111)
            $display("FAIL abort_pre_data obs=%b exp=1111", {dout_m, dout_l, busy_m, busy_l});
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        obs = {dout_m, busy_m, fd_m, if_m.in_ready, dout_l, busy_l, fd_l, if_l.in_ready};
        total_cnt++;
        if (obs !== 8'b0001_0001) $display("FAIL abort_async obs=%b exp=00010001", obs);
        else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < F + 3; i++) begin
            @(negedge clk);
            obs = {dout_m, busy_m, fd_m, if_m.in_ready, dout_l, busy_l, fd_l, if_l.in_ready};
            total_cnt++;
            if (obs !== 8'b0001_0001) $display("FAIL abort_quiet cyc=%0d obs=%b exp=00010001", i, obs);
            else pass_cnt++;
        end
        test_single_frame("after_abort_ff", 8'hFF);
    endtask

`ifdef SER_TX_PARITY_EN
    task automatic test_parity();
        test_single_frame("parity_07", 8'h07);
        test_single_frame("parity_03", 8'h03);
    endtask
`endif

    initial begin
        test_reset();
        test_frames();
        test_back_to_back();
        test_abort();
`ifdef SER_TX_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
